// File: rtl/k_fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO built around an external
// dual-port RAM (registered write, combinational read).
module k_fifo_ctrl #(
    parameter int ptr_size = 1,
    parameter int af_level = 1,
    parameter int ae_level = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                ram_wen,
    output logic [ptr_size-1:0] ram_waddr,
    output logic [ptr_size-1:0] ram_raddr,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ptr_size:0]   count
);

    localparam int PW = ptr_size + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(af_level);
    localparam logic [PW-1:0] AE_LVL = PW'(ae_level);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          push, pop;

    assign empty        = (wptr_q == rptr_q);
    assign full         = (wptr_q[ptr_size] != rptr_q[ptr_size]) &&
                          (wptr_q[ptr_size-1:0] == rptr_q[ptr_size-1:0]);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // A flush cycle must not leave a stale word behind in the RAM array.
    assign ram_wen   = push & !flush;
    assign ram_waddr = wptr_q[ptr_size-1:0];
    assign ram_raddr = rptr_q[ptr_size-1:0];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule
